// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw PS/2 lines, deframes
// 11-bit frames and holds the byte for a PIO-style consumer with ACK handshake.
module ps2_rx #(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       ACK,
    output logic       PERR,
    output logic       OVR,
    input  logic       ERR_CLR,
    output logic       BUSY
);

    localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic              clk_meta;
    logic              clk_sync;
    logic              dat_meta;
    logic              dat_sync;
    logic              filt_clk;
    logic              filt_prev;
    logic [FILT_W-1:0] filt_cnt;
    logic              strobe_c;

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_d;
    logic              par_bit;
    logic              par_bit_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_d;
    logic              done_c;
    logic              perr_c;

    // Two-flop synchronizers; idle PS/2 lines are high.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    // Glitch filter: the filtered clock follows only a run of FILT_LEN differing samples.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
                filt_clk <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    assign strobe_c = filt_prev & ~filt_clk;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and frame datapath.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        par_bit_d = par_bit;
        tmo_cnt_d = tmo_cnt;
        done_c    = 1'b0;

        if (state != ST_IDLE) begin
            tmo_cnt_d = strobe_c ? '0 : tmo_cnt + TMO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (strobe_c && !dat_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (strobe_c) begin
                    shift_d   = {dat_sync, shift[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (strobe_c) begin
                    par_bit_d = dat_sync;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe_c) begin
                    done_c  = dat_sync;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandon a stalled frame; a strobe in the same cycle keeps it alive.
        if ((state != ST_IDLE) && !strobe_c && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
        end
    end

    // Odd parity over data plus parity bit; even total means error.
    assign perr_c = ~(^{shift, par_bit});

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            par_bit <= par_bit_d;
            tmo_cnt <= tmo_cnt_d;
        end
    end

    // Consumer-facing holding register; a new byte beats a concurrent ACK clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DATA  <= '0;
            VALID <= 1'b0;
            PERR  <= 1'b0;
            OVR   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            if (done_c && (!VALID || ACK)) begin
                DATA  <= shift;
                PERR  <= perr_c;
                VALID <= 1'b1;
            end else if (ACK) begin
                VALID <= 1'b0;
            end

            if (done_c && VALID && !ACK) begin
                OVR <= 1'b1;
            end else if (ERR_CLR) begin
                OVR <= 1'b0;
            end

            BUSY <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed PS/2 frames against an event-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_ps2_rx;

    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 300;
    // Edges from driving PS2_CLK low to the edge that consumes the bit:
    // two synchronizer flops, FILT_LEN filter samples, one strobe cycle.
    localparam int LAT = FILT_LEN + 3;

    localparam int R_START = 0;
    localparam int R_MID   = 1;
    localparam int R_STOP  = 2;

    logic       CLK;
    logic       RST_N;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] DATA;
    logic       VALID;
    logic       ACK;
    logic       PERR;
    logic       OVR;
    logic       ERR_CLR;
    logic       BUSY;

    ps2_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .DATA    (DATA),
        .VALID   (VALID),
        .ACK     (ACK),
        .PERR    (PERR),
        .OVR     (OVR),
        .ERR_CLR (ERR_CLR),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         at;
        int         role;
        logic [7:0] d;
        logic       pe;
        logic       ok;
    } ev_t;

    ev_t        evq[$];
    ev_t        m_ev;
    int         cyc = 0;
    int         m_last = 0;
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_done;
    logic       m_ovr_set;
    bit         chk_en = 1'b0;
    bit         ack_on_stop = 1'b0;
    bit         clr_on_stop = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: frame outcomes are posted by the stimulus; handshake rules applied per edge.
    always @(posedge CLK) begin
        cyc++;
        if (!RST_N) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_perr  = 1'b0;
            m_ovr   = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy && (cyc == m_last + TIMEOUT_CYC)) m_busy = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                m_ev = evq.pop_front();
                if (m_ev.role == R_START) begin
                    m_busy = 1'b1;
                    m_last = cyc;
                end else if (m_ev.role == R_MID) begin
                    m_last = cyc;
                end else begin
                    m_busy = 1'b0;
                    m_done = m_ev.ok;
                end
            end
            m_ovr_set = m_done && m_valid && !ACK;
            if (m_done && (!m_valid || ACK)) begin
                m_data  = m_ev.d;
                m_perr  = m_ev.pe;
                m_valid = 1'b1;
            end else if (ACK && m_valid) begin
                m_valid = 1'b0;
            end
            if (m_ovr_set) m_ovr = 1'b1;
            else if (ERR_CLR) m_ovr = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_data",  32'(DATA),  32'(m_data));
            chk("cyc_valid", 32'(VALID), 32'(m_valid));
            chk("cyc_perr",  32'(PERR),  32'(m_perr));
            chk("cyc_ovr",   32'(OVR),   32'(m_ovr));
            chk("cyc_busy",  32'(BUSY),  32'(m_busy));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int role, input logic [7:0] d,
                           input logic pe, input logic ok);
        ev_t e;
        PS2_DAT = b;
        repeat (4) tick();
        PS2_CLK = 1'b0;
        e.at   = cyc + LAT;
        e.role = role;
        e.d    = d;
        e.pe   = pe;
        e.ok   = ok;
        evq.push_back(e);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (role == R_STOP && i == LAT - 1) begin
                if (ack_on_stop) ACK = 1'b1;
                if (clr_on_stop) ERR_CLR = 1'b1;
            end
            if (role == R_STOP && i == LAT) begin
                if (ack_on_stop) ACK = 1'b0;
                if (clr_on_stop) ERR_CLR = 1'b0;
            end
        end
        PS2_CLK = 1'b1;
        repeat (8) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int ndata);
        logic pe;
        pe = ~(^d ^ par);
        ps2_bit(1'b0, R_START, d, pe, stp);
        for (int i = 0; i < ndata; i++) ps2_bit(d[i], R_MID, d, pe, stp);
        if (ndata == 8) begin
            ps2_bit(par, R_MID, d, pe, stp);
            ps2_bit(stp, R_STOP, d, pe, stp);
        end
        PS2_DAT = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_ack();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
    endtask

    task automatic pulse_clr();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        tick();
    endtask

    initial begin
        RST_N   = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        ACK     = 1'b0;
        ERR_CLR = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_data",  32'(DATA),  32'h00);
        chk("rst_valid", 32'(VALID), 32'h0);
        chk("rst_perr",  32'(PERR),  32'h0);
        chk("rst_ovr",   32'(OVR),   32'h0);
        chk("rst_busy",  32'(BUSY),  32'h0);
        RST_N = 1'b1;
        repeat (4) tick();

        // Good frame 0x1C (three ones, parity 0 makes the total odd).
        send_frame(8'h1C, 1'b0, 1'b1, 8);
        chk("f1c_data",  32'(DATA),  32'h1C);
        chk("f1c_perr",  32'(PERR),  32'h0);
        chk("f1c_valid", 32'(VALID), 32'h1);
        pulse_ack();
        chk("ack_valid", 32'(VALID), 32'h0);
        chk("ack_data",  32'(DATA),  32'h1C);

        // Bad parity is still delivered.
        send_frame(8'h1C, 1'b1, 1'b1, 8);
        chk("perr_data",  32'(DATA),  32'h1C);
        chk("perr_flag",  32'(PERR),  32'h1);
        chk("perr_valid", 32'(VALID), 32'h1);
        pulse_ack();

        // Overrun: second byte dropped, first held.
        send_frame(8'h1C, 1'b0, 1'b1, 8);
        send_frame(8'hF0, 1'b1, 1'b1, 8);
        chk("ovr_data", 32'(DATA), 32'h1C);
        chk("ovr_set",  32'(OVR),  32'h1);
        pulse_clr();
        chk("ovr_clr",  32'(OVR),  32'h0);
        pulse_ack();
        chk("ovr_ack",  32'(VALID), 32'h0);
        send_frame(8'hF0, 1'b1, 1'b1, 8);
        chk("f0_data", 32'(DATA), 32'hF0);
        chk("f0_perr", 32'(PERR), 32'h0);
        pulse_ack();

        // Short glitch is filtered out; a FILT_LEN pulse with data high is an ignored strobe.
        PS2_CLK = 1'b0;
        repeat (FILT_LEN - 1) tick();
        PS2_CLK = 1'b1;
        repeat (12) tick();
        chk("glitch_busy",  32'(BUSY),  32'h0);
        chk("glitch_valid", 32'(VALID), 32'h0);
        PS2_CLK = 1'b0;
        repeat (FILT_LEN) tick();
        PS2_CLK = 1'b1;
        repeat (12) tick();
        chk("idle1_busy", 32'(BUSY), 32'h0);

        // Stall after four data bits until the frame times out.
        send_frame(8'h5A, 1'b1, 1'b1, 4);
        chk("stall_busy", 32'(BUSY), 32'h1);
        repeat (TIMEOUT_CYC + 20) tick();
        chk("tmo_busy", 32'(BUSY), 32'h0);
        send_frame(8'h5A, 1'b1, 1'b1, 8);
        chk("f5a_data",  32'(DATA),  32'h5A);
        chk("f5a_perr",  32'(PERR),  32'h0);
        chk("f5a_valid", 32'(VALID), 32'h1);

        // ACK on the completion edge: the new byte loads and VALID stays set.
        ack_on_stop = 1'b1;
        send_frame(8'hF0, 1'b1, 1'b1, 8);
        ack_on_stop = 1'b0;
        chk("lw_data",  32'(DATA),  32'hF0);
        chk("lw_valid", 32'(VALID), 32'h1);
        chk("lw_ovr",   32'(OVR),   32'h0);

        // ERR_CLR on the overrun edge: overrun wins.
        clr_on_stop = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, 8);
        clr_on_stop = 1'b0;
        chk("ow_data", 32'(DATA), 32'hF0);
        chk("ow_ovr",  32'(OVR),  32'h1);
        pulse_clr();
        pulse_ack();

        // Framing error: stop bit 0 discards the frame.
        send_frame(8'h5A, 1'b1, 1'b0, 8);
        chk("fe_valid", 32'(VALID), 32'h0);
        chk("fe_ovr",   32'(OVR),   32'h0);
        chk("fe_busy",  32'(BUSY),  32'h0);

        // Reset mid-frame, then a clean frame.
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        chk("mid_busy", 32'(BUSY), 32'h1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("mrst_busy", 32'(BUSY), 32'h0);
        chk("mrst_data", 32'(DATA), 32'h00);
        repeat (4) tick();
        send_frame(8'h1C, 1'b0, 1'b1, 8);
        chk("post_data",  32'(DATA),  32'h1C);
        chk("post_valid", 32'(VALID), 32'h1);
        pulse_ack();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
